// File: rtl/one_hot_pkg.sv
// Shared definitions for the one-hot bank/way pointer: rotate directions and
// vector helpers. Helpers take a zero-extended vector of OH_MAX_W bits.
package one_hot_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int OH_MAX_W = 256;

    // OR of the indices of all set bits; exact for a one-hot input.
    function automatic int unsigned onehot_encode(input logic [OH_MAX_W-1:0] vec);
        int unsigned idx;
        idx = 32'd0;
        for (int i = 0; i < OH_MAX_W; i++) begin
            if (vec[i]) begin
                idx = idx | i;
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic int unsigned onehot_count(input logic [OH_MAX_W-1:0] vec);
        int unsigned cnt;
        cnt = 32'd0;
        for (int i = 0; i < OH_MAX_W; i++) begin
            cnt = cnt + {31'd0, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/one_hot_encoder.sv
// Combinational one-hot to binary encoder used for the pointer index readback.
module one_hot_encoder
    import one_hot_pkg::*;
#(
    parameter int NUM_OUTS  = 8,
    parameter int SEL_WIDTH = 3
) (
    input  logic [NUM_OUTS-1:0]  onehot_i,
    output logic [SEL_WIDTH-1:0] index_o
);

    assign index_o = SEL_WIDTH'(onehot_encode(OH_MAX_W'(onehot_i)));

endmodule

// File: rtl/one_hot_sequencer.sv
// Registered one-hot bank/way pointer with binary load and wrap-around rotate.
// Optional state integrity checker enabled by defining ONE_HOT_SEQ_CHECK_EN.
module one_hot_sequencer
    import one_hot_pkg::*;
#(
    parameter int SEL_WIDTH   = 3,
    parameter int NUM_OUTS    = 8,
    parameter int RESET_INDEX = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 load,
    input  logic [SEL_WIDTH-1:0] cod,
    input  logic                 shift,
    input  logic                 dir,
    output logic [NUM_OUTS-1:0]  onehot_o,
    output logic [SEL_WIDTH-1:0] index_o,
    output logic                 wrap_o,
    output logic                 err_o
`ifdef ONE_HOT_SEQ_CHECK_EN
    ,
    output logic                 onehot_err_o
`endif
);

    generate
        if (NUM_OUTS < 2 || NUM_OUTS > (2 ** SEL_WIDTH)) begin : g_bad_num_outs
            $error("one_hot_sequencer: NUM_OUTS out of range 2..2**SEL_WIDTH");
        end
        if (RESET_INDEX < 0 || RESET_INDEX >= NUM_OUTS) begin : g_bad_reset_index
            $error("one_hot_sequencer: RESET_INDEX out of range 0..NUM_OUTS-1");
        end
    endgenerate

    localparam logic [NUM_OUTS-1:0]  ONE_VEC    = {{(NUM_OUTS-1){1'b0}}, 1'b1};
    localparam logic [NUM_OUTS-1:0]  RESET_VEC  = ONE_VEC << RESET_INDEX;
    localparam logic [SEL_WIDTH:0]   NUM_OUTS_W = (SEL_WIDTH+1)'(NUM_OUTS);

    logic [NUM_OUTS-1:0] state_q, state_d;
    logic                wrap_q, wrap_d;
    logic                err_q, err_d;
`ifdef ONE_HOT_SEQ_CHECK_EN
    logic                oh_err_q, oh_err_d;
`endif

    // Next-state selection: load beats shift, out-of-range codes hold state.
    always_comb begin
        state_d = state_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        if (load) begin
            if ({1'b0, cod} < NUM_OUTS_W) begin
                state_d = ONE_VEC << cod;
            end else begin
                err_d = 1'b1;
            end
        end else if (shift) begin
            if (dir == DIR_UP) begin
                state_d = {state_q[NUM_OUTS-2:0], state_q[NUM_OUTS-1]};
                wrap_d  = state_q[NUM_OUTS-1];
            end else begin
                state_d = {state_q[0], state_q[NUM_OUTS-1:1]};
                wrap_d  = state_q[0];
            end
        end else begin
            state_d = state_q;
        end
`ifdef ONE_HOT_SEQ_CHECK_EN
        oh_err_d = 1'b0;
        if (onehot_count(OH_MAX_W'(state_q)) != 32'd1) begin
            oh_err_d = 1'b1;
            state_d  = RESET_VEC;
            wrap_d   = 1'b0;
            err_d    = 1'b0;
        end else begin
            oh_err_d = 1'b0;
        end
`endif
    end

    // State and status pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RESET_VEC;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef ONE_HOT_SEQ_CHECK_EN
            oh_err_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wrap_q   <= wrap_d;
            err_q    <= err_d;
`ifdef ONE_HOT_SEQ_CHECK_EN
            oh_err_q <= oh_err_d;
`endif
        end
    end

    one_hot_encoder #(
        .NUM_OUTS  (NUM_OUTS),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_encoder (
        .onehot_i (state_q),
        .index_o  (index_o)
    );

    // enable only gates the select lines; readback and state ignore it.
    assign onehot_o = state_q & {NUM_OUTS{enable}};
    assign wrap_o   = wrap_q;
    assign err_o    = err_q;
`ifdef ONE_HOT_SEQ_CHECK_EN
    assign onehot_err_o = oh_err_q;
`endif

endmodule

// File: tb/tb_one_hot_sequencer.sv
// Scoreboard bench: an 8-output and a 6-output pointer share random stimulus
// and are compared against an integer-index reference model.
module tb_one_hot_sequencer;

    typedef struct {
        logic [7:0] oh;
        logic [2:0] idx;
        logic       wrap;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, enable, load, shift, dir;
    logic [2:0] cod;
    logic [7:0] oh8;
    logic [2:0] ix8;
    logic       w8, e8;
    logic [5:0] oh6;
    logic [2:0] ix6;
    logic       w6, e6;
`ifdef ONE_HOT_SEQ_CHECK_EN
    logic       ce8, ce6;
`endif

    int checks = 0;
    int errors = 0;
    int idx8   = 0;
    int idx6   = 3;
    exp_t q8[$];
    exp_t q6[$];

    always #5 clk = ~clk;

    one_hot_sequencer #(.SEL_WIDTH(3), .NUM_OUTS(8), .RESET_INDEX(0)) dut8 (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .cod(cod),
        .shift(shift), .dir(dir), .onehot_o(oh8), .index_o(ix8),
        .wrap_o(w8), .err_o(e8)
`ifdef ONE_HOT_SEQ_CHECK_EN
        , .onehot_err_o(ce8)
`endif
    );

    one_hot_sequencer #(.SEL_WIDTH(3), .NUM_OUTS(6), .RESET_INDEX(3)) dut6 (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .cod(cod),
        .shift(shift), .dir(dir), .onehot_o(oh6), .index_o(ix6),
        .wrap_o(w6), .err_o(e6)
`ifdef ONE_HOT_SEQ_CHECK_EN
        , .onehot_err_o(ce6)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the pointer is just an integer position on a ring of n slots.
    task automatic mstep(input int idx_in, input int n, input bit ld, input int cd,
                         input bit sh, input bit dr,
                         output int idx_out, output bit w, output bit e);
        idx_out = idx_in;
        w = 1'b0;
        e = 1'b0;
        if (ld) begin
            if (cd < n) idx_out = cd;
            else e = 1'b1;
        end else if (sh && !dr) begin
            w = (idx_in == n - 1);
            idx_out = (idx_in + 1) % n;
        end else if (sh && dr) begin
            w = (idx_in == 0);
            idx_out = (idx_in + n - 1) % n;
        end
    endtask

    function automatic exp_t mk(input int idx, input bit en, input bit w, input bit e);
        exp_t x;
        logic [7:0] one;
        one    = 8'h01;
        x.oh   = en ? (one << idx) : 8'h00;
        x.idx  = 3'(idx);
        x.wrap = w;
        x.err  = e;
        return x;
    endfunction

    task automatic step(input bit ld, input logic [2:0] cd, input bit sh,
                        input bit dr, input bit en);
        int n;
        bit w, e;
        @(negedge clk);
        load = ld; cod = cd; shift = sh; dir = dr; enable = en;
        mstep(idx8, 8, ld, int'(cd), sh, dr, n, w, e);
        idx8 = n;
        q8.push_back(mk(idx8, en, w, e));
        mstep(idx6, 6, ld, int'(cd), sh, dr, n, w, e);
        idx6 = n;
        q6.push_back(mk(idx6, en, w, e));
        @(posedge clk);
    endtask

    // Monitor: outputs are valid every cycle; compare whatever was scheduled.
    always @(posedge clk) begin
        #1;
        if (q8.size() > 0) begin
            exp_t x;
            x = q8.pop_front();
            chk("oh8",   {24'd0, oh8}, {24'd0, x.oh});
            chk("idx8",  {29'd0, ix8}, {29'd0, x.idx});
            chk("wrap8", {31'd0, w8},  {31'd0, x.wrap});
            chk("err8",  {31'd0, e8},  {31'd0, x.err});
        end
        if (q6.size() > 0) begin
            exp_t x;
            x = q6.pop_front();
            chk("oh6",   {26'd0, oh6}, {24'd0, x.oh});
            chk("idx6",  {29'd0, ix6}, {29'd0, x.idx});
            chk("wrap6", {31'd0, w6},  {31'd0, x.wrap});
            chk("err6",  {31'd0, e6},  {31'd0, x.err});
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b1; load = 1'b0; shift = 1'b0; dir = 1'b0; cod = 3'd0;
        repeat (2) @(negedge clk);
        chk("rst_oh8",   {24'd0, oh8}, 32'h01);
        chk("rst_idx8",  {29'd0, ix8}, 32'd0);
        chk("rst_wrap8", {31'd0, w8},  32'd0);
        chk("rst_err8",  {31'd0, e8},  32'd0);
        chk("rst_oh6",   {26'd0, oh6}, 32'h08);
        chk("rst_idx6",  {29'd0, ix6}, 32'd3);
        enable = 1'b0;
        #1;
        chk("rst_gated_oh8",  {24'd0, oh8}, 32'h00);
        chk("rst_gated_idx8", {29'd0, ix8}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        enable = 1'b1;

        step(1'b1, 3'd5, 1'b0, 1'b0, 1'b1);
        step(1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'd7, 1'b0, 1'b0, 1'b1);
        step(1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 3'd0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 3'd5, 1'b0, 1'b0, 1'b1);
        step(1'b1, 3'd6, 1'b0, 1'b0, 1'b1);
        step(1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 3'd2, 1'b1, 1'b0, 1'b1);

        // Reset lands in the middle of a shift burst.
        repeat (3) step(1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        shift = 1'b1;
        #2 reset = 1'b1;
        #1;
        idx8 = 0;
        idx6 = 3;
        chk("midrst_idx8",  {29'd0, ix8}, 32'd0);
        chk("midrst_oh8",   {24'd0, oh8}, 32'h01);
        chk("midrst_wrap8", {31'd0, w8},  32'd0);
        chk("midrst_idx6",  {29'd0, ix6}, 32'd3);
        @(negedge clk);
        reset = 1'b0;
        shift = 1'b0;

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 4) != 0));
        end

`ifdef ONE_HOT_SEQ_CHECK_EN
        @(negedge clk);
        load = 1'b0; shift = 1'b0; enable = 1'b1;
        dut8.state_q = 8'h09;
        @(posedge clk);
        #1;
        chk("chk_err",  {31'd0, ce8}, 32'd1);
        chk("chk_fix",  {24'd0, oh8}, 32'h01);
        idx8 = 0;
        @(posedge clk);
        #1;
        chk("chk_pulse", {31'd0, ce8}, 32'd0);
`endif

        repeat (2) @(negedge clk);
        chk("queue_drain", q8.size() + q6.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/one_hot_sequencer.md
Name: one_hot_sequencer

Overview:
Parametrised, registered successor to the combinational 3-to-8 one-hot decoder used for bank/write-enable select in the MEM stage.
- Holds a one-hot select vector in a state register.
- The vector can be loaded from a binary code or rotated one position up or down per cycle, with wrap-around.
- Outputs are gated by enable and accompanied by binary readback, wrap and error indications.
- Serves as bank/way pointer for memory and register-file write-select logic.

Parameters:
SEL_WIDTH, 3, width of binary code and index readback.
NUM_OUTS, 8, number of one-hot outputs; legal range 2..2**SEL_WIDTH (elaboration error otherwise).
RESET_INDEX, 0, index whose bit is set after reset; legal range 0..NUM_OUTS-1.

Ports:
clk  in  1  clock, rising-edge.
reset  in  1  asynchronous, active-high reset.
enable  in  1  output gate; 0 forces onehot_o to all zeros, state unaffected.
load  in  1  load state from cod on next edge.
cod  in  SEL_WIDTH  binary index for load.
shift  in  1  rotate state by one position on next edge.
dir  in  1  rotate direction: 0 = up (bit i -> i+1), 1 = down (bit i -> i-1).
onehot_o  out  NUM_OUTS  state & {NUM_OUTS{enable}}.
index_o  out  SEL_WIDTH  binary index of the set state bit, ungated by enable.
wrap_o  out  1  registered 1-cycle pulse: last shift wrapped around.
err_o  out  1  registered 1-cycle pulse: last load had cod >= NUM_OUTS.

Behaviour:
- Reset (asynchronous, active-high):
  - state = 1 << RESET_INDEX.
  - wrap_o = 0, err_o = 0.
  - onehot_o reflects the reset state gated by enable.
  - index_o = RESET_INDEX.
- Reset asserted mid-operation overrides any load/shift in flight immediately; no partial update survives.
- Each rising edge, in priority order:
  1. load=1, cod < NUM_OUTS: state = 1 << cod; wrap_o = 0; err_o = 0.
  2. load=1, cod >= NUM_OUTS (only possible when NUM_OUTS < 2**SEL_WIDTH): state held; err_o = 1; wrap_o = 0.
  3. load=0, shift=1, dir=0: state rotates up. If state[NUM_OUTS-1] was set, bit 0 becomes set and wrap_o = 1.
  4. load=0, shift=1, dir=1: state rotates down. If state[0] was set, bit NUM_OUTS-1 becomes set and wrap_o = 1.
  5. Otherwise: state held; wrap_o = 0; err_o = 0.
- load and shift asserted together: load wins and the shift is dropped (no wrap_o).
- Latency: load/shift takes effect on onehot_o and index_o one cycle after the sampling edge.
- enable gating is combinational with zero latency and does not block load/shift.
- Rotation wraps at NUM_OUTS, not at 2**SEL_WIDTH. Example: NUM_OUTS=6, index 5 up -> index 0.
- index_o is the combinational one-hot-to-binary encode of state.
- State is exactly one-hot at all times in fault-free operation.

Optional Feature:
Macro ONE_HOT_SEQ_CHECK_EN.
- Defined:
  - Adds output port onehot_err_o (1 bit, registered).
  - Each cycle the state is checked for exactly one set bit.
  - On violation: onehot_err_o = 1 for one cycle, and state is forced to 1 << RESET_INDEX on the same edge, overriding load/shift.
  - onehot_err_o resets to 0.
- Undefined: no checker, no extra port; a corrupted state propagates unchanged.

Decomposition:
- Package one_hot_pkg:
  - direction constants DIR_UP=1'b0, DIR_DOWN=1'b1.
  - function onehot_encode for readback.
  - function onehot_count for the optional checker.
- Sub-module one_hot_encoder (NUM_OUTS -> SEL_WIDTH combinational encoder) is instantiated for index_o; everything else stays in one_hot_sequencer.

Test Plan:
- Reset with RESET_INDEX=0, enable=1 -> onehot_o=8'h01, index_o=0, wrap_o=0, err_o=0; enable=0 -> onehot_o=8'h00, index_o=0.
- load=1, cod=3'd5 -> next cycle onehot_o=8'h20, index_o=5; same load with enable=0 -> onehot_o=8'h00, index_o=5.
- Load 7, then shift=1, dir=0 for 1 cycle -> onehot_o=8'h01, wrap_o=1 for one cycle. Shift down from index 0 -> onehot_o=8'h80, wrap_o=1.
- NUM_OUTS=6, SEL_WIDTH=3:
  - load cod=6 -> state unchanged, err_o=1 one cycle.
  - shift up from index 5 -> index 0, wrap_o=1.
- load=1, cod=2 with shift=1, dir=0 in the same cycle -> index_o=2, wrap_o=0. Then assert reset mid-shift burst -> index_o=RESET_INDEX immediately.
- With ONE_HOT_SEQ_CHECK_EN defined, force state=8'h09 -> onehot_err_o=1 one cycle, state=8'h01 next cycle.
